// File: rtl/rs_pkg.sv
// rs_pkg: shared types for the adder reservation station.
// Entry states, the "value available" tag and a width helper.
package rs_pkg;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } rs_state_e;

  localparam int TAG_AVAIL = 0;

  // ceil(log2(v)), never below 1 so ports keep a legal width
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rs_prio_pick.sv
// rs_prio_pick: lowest-index priority encoder.
// Returns one-hot grant, its index and an any-request flag.
module rs_prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rs_adder_station.sv
// rs_adder_station: Tomasulo reservation station for the adder unit.
// Renames via a register-status table, snoops the CDB, dispatches registered.
module rs_adder_station
  import rs_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int DATA_W    = 16,
  parameter int NREG      = 8,
  parameter int OP_W      = 3,
  parameter int TAG_BASE  = 1,
  parameter int TAG_W     = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [OP_W-1:0]               issue_op,
  input  logic [clog2(NREG)-1:0]        issue_rd,
  input  logic [clog2(NREG)-1:0]        issue_rs1,
  input  logic [clog2(NREG)-1:0]        issue_rs2,
  output logic [clog2(NREG)-1:0]        rf_raddr1,
  output logic [clog2(NREG)-1:0]        rf_raddr2,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic                          cdb_valid,
  input  logic [TAG_W-1:0]              cdb_tag,
  input  logic [DATA_W-1:0]             cdb_data,
  output logic                          fu_valid,
  input  logic                          fu_ready,
  output logic [OP_W-1:0]               fu_op,
  output logic [DATA_W-1:0]             fu_vj,
  output logic [DATA_W-1:0]             fu_vk,
  output logic [TAG_W-1:0]              fu_tag,
  output logic [clog2(N_ENTRIES+1)-1:0] busy_count,
  output logic [NREG*TAG_W-1:0]         reg_status_o
);

  localparam int CW = clog2(N_ENTRIES + 1);
  localparam int IW = clog2(N_ENTRIES);
  localparam logic [TAG_W-1:0] AVAIL = TAG_W'(TAG_AVAIL);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    rs_state_e         st;
  } entry_t;

  entry_t           ent    [N_ENTRIES];
  entry_t           ent_n  [N_ENTRIES];
  entry_t           new_ent;
  logic [TAG_W-1:0] stat   [NREG];
  logic [TAG_W-1:0] stat_n [NREG];

  logic [N_ENTRIES-1:0] free_vec;
  logic [N_ENTRIES-1:0] free_oh;
  logic [N_ENTRIES-1:0] rdy_vec;
  logic [N_ENTRIES-1:0] rdy_oh;
  logic [IW-1:0]        free_idx;
  logic [IW-1:0]        rdy_idx;
  logic                 free_any;
  logic                 rdy_any;
  logic                 do_issue;
  logic                 load;
  logic                 free_ev;
  logic                 hold_valid;
  logic [TAG_W-1:0]     new_tag;
  logic [TAG_W-1:0]     s1;
  logic [TAG_W-1:0]     s2;

  assign rf_raddr1 = issue_rs1;
  assign rf_raddr2 = issue_rs2;

  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      free_vec[i] = ent[i].st == ST_FREE;
      rdy_vec[i]  = (ent[i].st == ST_WAIT || ent[i].st == ST_READY)
                 && ent[i].qj == AVAIL && ent[i].qk == AVAIL;
    end
  end

  rs_prio_pick #(.N(N_ENTRIES), .IW(IW)) u_free_pick (
    .req    (free_vec),
    .onehot (free_oh),
    .idx    (free_idx),
    .any    (free_any)
  );

  rs_prio_pick #(.N(N_ENTRIES), .IW(IW)) u_rdy_pick (
    .req    (rdy_vec),
    .onehot (rdy_oh),
    .idx    (rdy_idx),
    .any    (rdy_any)
  );

  assign issue_ready = free_any;
  assign do_issue    = issue_valid && free_any;
  assign load        = !hold_valid || fu_ready;
  assign fu_valid    = hold_valid;

  // sources read the old status; a result on the CDB this cycle bypasses
  always_comb begin
    s1         = stat[issue_rs1];
    s2         = stat[issue_rs2];
    new_tag    = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    new_ent    = '0;
    new_ent.op = issue_op;
    new_ent.st = ST_WAIT;
    if (s1 == AVAIL) new_ent.vj = rf_rdata1;
    else if (cdb_valid && cdb_tag == s1) new_ent.vj = cdb_data;
    else new_ent.qj = s1;
    if (s2 == AVAIL) new_ent.vk = rf_rdata2;
    else if (cdb_valid && cdb_tag == s2) new_ent.vk = cdb_data;
    else new_ent.qk = s2;
  end

  always_comb begin
    ent_n   = ent;
    stat_n  = stat;
    free_ev = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (cdb_valid && (ent[i].st == ST_WAIT || ent[i].st == ST_READY)) begin
        if (ent[i].qj != AVAIL && ent[i].qj == cdb_tag) begin
          ent_n[i].vj = cdb_data;
          ent_n[i].qj = AVAIL;
        end
        if (ent[i].qk != AVAIL && ent[i].qk == cdb_tag) begin
          ent_n[i].vk = cdb_data;
          ent_n[i].qk = AVAIL;
        end
      end
      if (cdb_valid && ent[i].st == ST_EXEC
          && cdb_tag == TAG_W'(TAG_BASE + i)) begin
        ent_n[i] = '0;
        free_ev  = 1'b1;
      end
      if (ent_n[i].st == ST_WAIT && ent_n[i].qj == AVAIL
          && ent_n[i].qk == AVAIL)
        ent_n[i].st = ST_READY;
      if (load && rdy_oh[i]) ent_n[i].st = ST_EXEC;
      if (do_issue && free_oh[i]) ent_n[i] = new_ent;
    end
    for (int r = 0; r < NREG; r++) begin
      if (cdb_valid && stat[r] == cdb_tag) stat_n[r] = AVAIL;
    end
    if (do_issue) stat_n[issue_rd] = new_tag;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_ENTRIES; i++) ent[i] <= '0;
      for (int r = 0; r < NREG; r++) stat[r] <= AVAIL;
      busy_count <= '0;
    end else begin
      ent        <= ent_n;
      stat       <= stat_n;
      busy_count <= busy_count + CW'(do_issue) - CW'(free_ev);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_valid <= 1'b0;
      fu_op      <= '0;
      fu_vj      <= '0;
      fu_vk      <= '0;
      fu_tag     <= '0;
    end else if (load) begin
      hold_valid <= rdy_any;
      if (rdy_any) begin
        fu_op  <= ent[rdy_idx].op;
        fu_vj  <= ent[rdy_idx].vj;
        fu_vk  <= ent[rdy_idx].vk;
        fu_tag <= TAG_W'(TAG_BASE) + TAG_W'(rdy_idx);
      end
    end
  end

  always_comb begin
    reg_status_o = '0;
    for (int r = 0; r < NREG; r++) reg_status_o[r*TAG_W +: TAG_W] = stat[r];
  end

endmodule

// File: tb/tb_rs_adder_station.sv
// tb_rs_adder_station: directed stimulus with a tag-level behavioural model
// checked every cycle, plus literal expectations for latency and ordering.
module tb_rs_adder_station;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int OW = 3;
  localparam int TB = 1;
  localparam int TW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [OW-1:0] issue_op = '0;
  logic [2:0]    issue_rd = '0;
  logic [2:0]    issue_rs1 = '0;
  logic [2:0]    issue_rs2 = '0;
  logic [2:0]    rf_raddr1;
  logic [2:0]    rf_raddr2;
  logic [DW-1:0] rf_rdata1 = '0;
  logic [DW-1:0] rf_rdata2 = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic          fu_valid;
  logic          fu_ready = 1'b1;
  logic [OW-1:0] fu_op;
  logic [DW-1:0] fu_vj;
  logic [DW-1:0] fu_vk;
  logic [TW-1:0] fu_tag;
  logic [2:0]    busy_count;
  logic [NR*TW-1:0] reg_status_o;

  rs_adder_station dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .fu_valid     (fu_valid),
    .fu_ready     (fu_ready),
    .fu_op        (fu_op),
    .fu_vj        (fu_vj),
    .fu_vk        (fu_vk),
    .fu_tag       (fu_tag),
    .busy_count   (busy_count),
    .reg_status_o (reg_status_o)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // model state, indexed by tag
  bit            m_busy [1:N];
  bit            m_disp [1:N];
  logic [OW-1:0] m_op   [1:N];
  logic [TW-1:0] m_qj   [1:N];
  logic [TW-1:0] m_qk   [1:N];
  logic [DW-1:0] m_vj   [1:N];
  logic [DW-1:0] m_vk   [1:N];
  logic [TW-1:0] m_stat [NR];

  bit            p_valid, p_ready;
  logic [TW-1:0] p_tag;
  logic [OW-1:0] p_op;
  logic [DW-1:0] p_vj, p_vk;

  int            nfree, slot, ft;
  bit            fin, m_iss;
  logic [TW-1:0] s, nqj, nqk;
  logic [DW-1:0] nvj, nvk;
  logic [NR*TW-1:0] flat;

  task automatic m_clear();
    for (int t = 1; t <= N; t++) begin
      m_busy[t] = 0;
      m_disp[t] = 0;
      m_qj[t]   = '0;
      m_qk[t]   = '0;
    end
    for (int r = 0; r < NR; r++) m_stat[r] = '0;
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      m_clear();
      p_valid = 1'b0;
    end else begin
      nfree = 0;
      slot  = 0;
      for (int t = N; t >= 1; t--) begin
        if (!m_busy[t]) begin
          nfree++;
          slot = t;
        end
      end
      chk("m_issue_ready", issue_ready, nfree != 0);
      chk("m_busy_count", busy_count, N - nfree);
      for (int r = 0; r < NR; r++) flat[r*TW +: TW] = m_stat[r];
      chk("m_reg_status", reg_status_o, flat);
      if (p_valid && !p_ready)
        chk("m_hold_stable", {fu_valid, fu_tag, fu_op, fu_vj, fu_vk},
            {1'b1, p_tag, p_op, p_vj, p_vk});
      ft  = int'(fu_tag);
      fin = ft >= TB && ft < TB + N;
      if (fu_valid) begin
        chk("m_fu_tag_live", fin && m_busy[ft], 1'b1);
        if (fin) begin
          chk("m_fu_payload", {fu_op, fu_vj, fu_vk},
              {m_op[ft], m_vj[ft], m_vk[ft]});
          chk("m_fu_ops_ready", {m_qj[ft], m_qk[ft]}, 8'h00);
          m_disp[ft] = 1;
        end
      end
      p_valid = fu_valid;
      p_ready = fu_ready;
      p_tag   = fu_tag;
      p_op    = fu_op;
      p_vj    = fu_vj;
      p_vk    = fu_vk;
      // resolve the incoming instruction against the old status
      m_iss = issue_valid && nfree != 0;
      nvj = '0; nvk = '0; nqj = '0; nqk = '0;
      s = m_stat[issue_rs1];
      if (s == 0) nvj = rf_rdata1;
      else if (cdb_valid && cdb_tag == s) nvj = cdb_data;
      else nqj = s;
      s = m_stat[issue_rs2];
      if (s == 0) nvk = rf_rdata2;
      else if (cdb_valid && cdb_tag == s) nvk = cdb_data;
      else nqk = s;
      if (cdb_valid) begin
        for (int t = 1; t <= N; t++) begin
          if (m_busy[t] && m_qj[t] != 0 && m_qj[t] == cdb_tag) begin
            m_vj[t] = cdb_data;
            m_qj[t] = '0;
          end
          if (m_busy[t] && m_qk[t] != 0 && m_qk[t] == cdb_tag) begin
            m_vk[t] = cdb_data;
            m_qk[t] = '0;
          end
        end
        if (int'(cdb_tag) >= TB && int'(cdb_tag) < TB + N) begin
          if (m_busy[cdb_tag] && m_disp[cdb_tag]) begin
            m_busy[cdb_tag] = 0;
            m_disp[cdb_tag] = 0;
          end
        end
        for (int r = 0; r < NR; r++)
          if (m_stat[r] == cdb_tag) m_stat[r] = '0;
      end
      if (m_iss) begin
        m_busy[slot] = 1;
        m_disp[slot] = 0;
        m_op[slot]   = issue_op;
        m_vj[slot]   = nvj;
        m_vk[slot]   = nvk;
        m_qj[slot]   = nqj;
        m_qk[slot]   = nqk;
        m_stat[issue_rd] = TW'(slot);
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic iss(input logic [2:0] op, input logic [2:0] rd,
                     input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic [15:0] d1, input logic [15:0] d2);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    rf_rdata1   = d1;
    rf_rdata2   = d2;
  endtask

  task automatic cdb(input logic [3:0] tg, input logic [15:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = tg;
    cdb_data  = d;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  function automatic logic [3:0] st(input int r);
    return reg_status_o[r*TW +: TW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    Reset = 1'b0;
    chk("rst_busy", busy_count, 0);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_status", reg_status_o, 0);

    // async reset with three entries busy
    fu_ready = 1'b0;
    iss(3'd1, 3'd1, 3'd6, 3'd7, 16'd1, 16'd2); cyc();
    iss(3'd1, 3'd2, 3'd6, 3'd7, 16'd3, 16'd4); cyc();
    iss(3'd1, 3'd3, 3'd6, 3'd7, 16'd5, 16'd6); cyc();
    idle();
    chk("mid_busy", busy_count, 3);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_count, 0);
    chk("mid_rst_fu_valid", fu_valid, 0);
    chk("mid_rst_issue_ready", issue_ready, 1);
    chk("mid_rst_status", reg_status_o, 0);
    cyc();
    Reset = 1'b0;
    fu_ready = 1'b1;
    cyc();

    // R3 = R1 + R2 with both sources available
    iss(3'd1, 3'd3, 3'd1, 3'd2, 16'd5, 16'd7);
    #1;
    chk("rf_raddr", {rf_raddr1, rf_raddr2}, {3'd1, 3'd2});
    cyc(); idle();
    chk("t2_latency", fu_valid, 0);
    chk("t2_stat3", st(3), 1);
    cyc();
    chk("t2_dispatch", {fu_valid, fu_vj, fu_vk, fu_tag},
        {1'b1, 16'd5, 16'd7, 4'd1});
    cyc();
    cdb(4'd1, 16'd12); cyc(); idle();
    chk("t2_free", {busy_count, st(3)}, {3'd0, 4'd0});

    // dependent chain R4 = R3 + R1
    iss(3'd1, 3'd3, 3'd1, 3'd2, 16'd5, 16'd7); cyc();
    iss(3'd2, 3'd4, 3'd3, 3'd1, 16'd99, 16'd5); cyc(); idle();
    chk("t3_first", {fu_valid, fu_tag, fu_vj}, {1'b1, 4'd1, 16'd5});
    cyc();
    chk("t3_waiting", fu_valid, 0);
    cdb(4'd1, 16'd12); cyc(); idle();
    chk("t3_stat3", st(3), 0);
    cyc();
    chk("t3_second", {fu_valid, fu_op, fu_vj, fu_vk, fu_tag},
        {1'b1, 3'd2, 16'd12, 16'd5, 4'd2});
    cyc();
    cdb(4'd2, 16'd17); cyc(); idle();
    chk("t3_free", {busy_count, st(4)}, {3'd0, 4'd0});

    // issue-time CDB bypass
    iss(3'd1, 3'd1, 3'd6, 3'd7, 16'd1, 16'd2); cyc(); idle();
    cyc();
    iss(3'd3, 3'd2, 3'd1, 3'd6, 16'd50, 16'd3);
    cdb(4'd1, 16'd9);
    cyc(); idle();
    chk("t4_stat", {st(1), st(2)}, {4'd0, 4'd2});
    cyc();
    chk("t4_bypass", {fu_valid, fu_vj, fu_vk, fu_tag},
        {1'b1, 16'd9, 16'd3, 4'd2});
    cyc();
    cdb(4'd2, 16'h55); cyc(); idle();
    chk("t4_free", busy_count, 0);

    // fill every entry while the unit stalls
    fu_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      iss(3'(i), 3'(i + 1), 3'd6, 3'd7, 16'(10 + i), 16'(20 + i));
      cyc();
    end
    idle();
    chk("t5_full", {issue_ready, busy_count}, {1'b0, 3'd4});
    iss(3'd5, 3'd5, 3'd6, 3'd7, 16'd77, 16'd77); cyc(); idle();
    chk("t5_ignored", {busy_count, st(5)}, {3'd4, 4'd0});
    chk("t5_stalled", {fu_valid, fu_tag, fu_vj}, {1'b1, 4'd1, 16'd10});
    fu_ready = 1'b1;
    for (int k = 2; k <= N; k++) begin
      cyc();
      chk("t5_order", {fu_valid, fu_tag, fu_vj}, {1'b1, 4'(k), 16'(9 + k)});
    end
    cyc();
    chk("t5_drained", fu_valid, 0);
    for (int k = 1; k <= N; k++) begin
      cdb(4'(k), 16'(k)); cyc();
    end
    idle();
    chk("t5_free", {busy_count, reg_status_o}, 35'd0);

    // issue to R5 while the CDB clears R5's old tag
    iss(3'd1, 3'd5, 3'd6, 3'd7, 16'd4, 16'd4); cyc(); idle();
    cyc();
    iss(3'd2, 3'd5, 3'd6, 3'd7, 16'd8, 16'd8);
    cdb(4'd1, 16'd8);
    cyc(); idle();
    chk("t6_stat5", st(5), 2);
    cyc();
    cyc();
    cdb(4'd2, 16'd16); cyc(); idle();
    chk("t6_free", {busy_count, st(5)}, {3'd0, 4'd0});

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
